// File: rtl/vedic_pkg.sv
// Shared constants and types for the sequential 53x53 significand multiplier
// built on a single 13x13 vedic multiplier.
package vedic_pkg;

  localparam int MANT_W = 53;
  localparam int LIMB_W = 13;
  localparam int NLIMB  = 5;
  localparam int NPP    = NLIMB * NLIMB;
  localparam int ACC_W  = NLIMB * LIMB_W * 2;
  localparam int PP_W   = 2 * LIMB_W;
  localparam int CNT_W  = $clog2(NPP);
  localparam int IDX_W  = $clog2(NLIMB);
  localparam int SH_W   = $clog2(2 * NLIMB - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  typedef logic [CNT_W-1:0]              cnt_t;
  typedef logic [IDX_W-1:0]              limb_idx_t;
  typedef logic [SH_W-1:0]               sh_t;
  typedef logic [LIMB_W-1:0]             limb_t;
  typedef logic [NLIMB-1:0][LIMB_W-1:0]  limbs_t;
  typedef logic [PP_W-1:0]               pp_t;
  typedef logic [ACC_W-1:0]              acc_t;
  typedef logic [MANT_W-1:0]             mant_t;
  typedef logic [2*MANT_W-1:0]           prod_t;

endpackage

// File: rtl/vedic_mant_mul_seq_if.sv
// Operand/product handshake bus of vedic_mant_mul_seq, plus the partial-product
// debug stream (pp_v/pp/pp_sh) that exposes the limb schedule.
interface vedic_mant_mul_seq_if;
  import vedic_pkg::*;

  logic  in_valid;
  logic  in_ready;
  mant_t a;
  mant_t b;
  logic  out_valid;
  logic  out_ready;
  prod_t p;
  logic  pp_v;
  pp_t   pp;
  sh_t   pp_sh;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, p, pp_v, pp, pp_sh
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, p, pp_v, pp, pp_sh
  );

endinterface

// File: rtl/vedic_13x13.sv
// Combinational 13x13 unsigned multiplier, Urdhva-Tiryagbhyam (vertical and
// crosswise) form: bit products are summed per column, then columns are weighted.
module vedic_13x13
  import vedic_pkg::*;
(
  input  limb_t a_i,
  input  limb_t b_i,
  output pp_t   p_o
);

  localparam int COL_W = 4;

  logic [PP_W-2:0][COL_W-1:0] col_sum;

  // NOTE: every variable gets a default before the loops so no path leaves it
  // unassigned, which would infer a latch; blocking '=' lets each loop step see
  // the running sum from the previous step.
  always_comb begin
    col_sum = '0;
    for (int i = 0; i < LIMB_W; i++) begin
      for (int j = 0; j < LIMB_W; j++) begin
        col_sum[i+j] = col_sum[i+j] + {{(COL_W-1){1'b0}}, a_i[i] & b_i[j]};
      end
    end
    p_o = '0;
    for (int k = 0; k < PP_W - 1; k++) begin
      p_o = p_o + (pp_t'(col_sum[k]) << k);
    end
  end

endmodule

// File: rtl/vedic_mant_mul_seq.sv
// Iterative 53x53 significand multiplier: 25 limb pairs through one vedic_13x13,
// shifted and accumulated. Define VEDIC_ZERO_BYPASS_EN to short-cut zero operands.
module vedic_mant_mul_seq
  import vedic_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  vedic_mant_mul_seq_if.slave bus,
  output logic                busy
);

  state_t    state_q;
  cnt_t      cnt_q;
  limbs_t    a_q;
  limbs_t    b_q;
  pp_t       pp_q;
  sh_t       sh_q;
  logic      pp_v_q;
  acc_t      acc_q;
  acc_t      acc_d;
  prod_t     p_q;
  logic      in_ready_q;
  logic      out_valid_q;
  logic      busy_q;
  limb_idx_t li;
  limb_idx_t lj;
  pp_t       mul_p;
  logic      accept;
  logic      zero_op;

  assign accept = bus.in_valid && in_ready_q;

  // Schedule is i-major, j-minor: cnt = 5*i + j.
  always_comb begin
    li = limb_idx_t'(cnt_q / cnt_t'(NLIMB));
    lj = limb_idx_t'(cnt_q % cnt_t'(NLIMB));
  end

  always_comb begin
    acc_d = acc_q;
    if (pp_v_q) begin
      acc_d = acc_q + (acc_t'(pp_q) << (LIMB_W * sh_q));
    end
  end

`ifdef VEDIC_ZERO_BYPASS_EN
  assign zero_op = (bus.a == '0) || (bus.b == '0);
`else
  assign zero_op = 1'b0;
`endif

  vedic_13x13 u_mul (
    .a_i (a_q[li]),
    .b_i (b_q[lj]),
    .p_o (mul_p)
  );

  // NOTE: sequential state uses non-blocking '<=' only, so every register sees
  // the pre-edge value of every other. The operand limbs and accumulator are
  // wide data registers but are reset anyway: an aborted operation must leave
  // nothing behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      pp_q        <= '0;
      sh_q        <= '0;
      pp_v_q      <= 1'b0;
      acc_q       <= '0;
      p_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      pp_v_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            a_q        <= limbs_t'({{(NLIMB*LIMB_W-MANT_W){1'b0}}, bus.a});
            b_q        <= limbs_t'({{(NLIMB*LIMB_W-MANT_W){1'b0}}, bus.b});
            acc_q      <= '0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            if (zero_op) begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
              p_q         <= '0;
            end else begin
              state_q <= RUN;
              busy_q  <= 1'b1;
            end
          end
        end
        RUN: begin
          pp_q   <= mul_p;
          sh_q   <= sh_t'(li) + sh_t'(lj);
          pp_v_q <= 1'b1;
          cnt_q  <= cnt_q + cnt_t'(1);
          if (cnt_q == cnt_t'(NPP - 1)) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          // acc_d already folds in the last partial product.
          state_q     <= DONE;
          busy_q      <= 1'b0;
          out_valid_q <= 1'b1;
          p_q         <= acc_d[2*MANT_W-1:0];
        end
        DONE: begin
          if (bus.out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.p         = p_q;
  assign bus.pp_v      = pp_v_q;
  assign bus.pp        = pp_q;
  assign bus.pp_sh     = sh_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_vedic_mant_mul_seq.sv
// Self-checking bench for vedic_mant_mul_seq: directed and random operands against
// a plain-arithmetic product model, latency, limb order, backpressure and reset.
module tb_vedic_mant_mul_seq;
  import vedic_pkg::*;

  logic clk;
  logic rst_n;
  logic busy;
  int   checks   = 0;
  int   failures = 0;

  vedic_mant_mul_seq_if bus ();

  vedic_mant_mul_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One complete operation: accept, watch the partial-product stream, check the
  // product and latency, hold the result under backpressure, then release.
  task automatic run_op(input mant_t av, input mant_t bv, input int hold);
    logic [NLIMB*LIMB_W-1:0] ax, bx;
    prod_t held;
    prod_t exp_p;
    pp_t   exp_pp;
    limb_t la, lb;
    bit    bypass, busy_seen;
    int    n, k, wait_n, exp_lat, exp_npp, ii, jj;

    exp_p = {{MANT_W{1'b0}}, av} * {{MANT_W{1'b0}}, bv};
    ax = '0; ax[MANT_W-1:0] = av;
    bx = '0; bx[MANT_W-1:0] = bv;
    bypass = 1'b0;
`ifdef VEDIC_ZERO_BYPASS_EN
    bypass = (av == '0) || (bv == '0);
`endif
    // Edges counted after the accepting edge; the bypass result is already
    // visible right after the accepting edge itself.
    exp_lat = bypass ? 0 : NPP + 1;
    exp_npp = bypass ? 0 : NPP;

    wait_n = 0;
    while (!bus.in_ready && wait_n < 50) begin
      @(posedge clk); #1; wait_n++;
    end
    check("in_ready_before_accept", bus.in_ready, 1'b1);

    bus.in_valid = 1'b1;
    bus.a = av;
    bus.b = bv;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.a = mant_t'({$urandom, $urandom});
    bus.b = mant_t'({$urandom, $urandom});
    check("busy_after_accept", busy, !bypass);
    busy_seen = busy;

    n = 0;
    k = 0;
    while (!bus.out_valid && n < 40) begin
      @(posedge clk); #1; n++;
      if (busy) busy_seen = 1'b1;
      if (bus.pp_v) begin
        if (k < NPP) begin
          ii = k / NLIMB;
          jj = k % NLIMB;
          la = limb_t'(ax >> (LIMB_W * ii));
          lb = limb_t'(bx >> (LIMB_W * jj));
          exp_pp = pp_t'(la) * pp_t'(lb);
          check("pp_value", bus.pp, exp_pp);
          check("pp_shift", bus.pp_sh, ii + jj);
        end else begin
          check("pp_extra", bus.pp_v, 1'b0);
        end
        k++;
      end
    end
    check("latency", n, exp_lat);
    check("pp_count", k, exp_npp);
    check("busy_seen", busy_seen, !bypass);
    check("busy_in_done", busy, 1'b0);
    check("product", bus.p, exp_p);
    held = bus.p;

    for (int h = 0; h < hold; h++) begin
      bus.in_valid = 1'b1;
      bus.a = mant_t'({$urandom, $urandom});
      @(posedge clk); #1;
      check("hold_p_stable", bus.p, held);
      check("hold_out_valid", bus.out_valid, 1'b1);
      check("hold_in_ready", bus.in_ready, 1'b0);
    end
    bus.in_valid = 1'b0;

    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("release_out_valid", bus.out_valid, 1'b0);
    check("release_in_ready", bus.in_ready, 1'b1);
  endtask

  initial begin
    logic [63:0] ra, rb;
    int   seen_valid;
    mant_t all_ones;

    all_ones      = '1;
    rst_n         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;

    #1 rst_n = 1'b0;
    #1;
    check("reset_in_ready", bus.in_ready, 1'b1);
    check("reset_out_valid", bus.out_valid, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_p", bus.p, '0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(53'd1, 53'd1, 0);
    run_op(all_ones, all_ones, 2);
    run_op(53'h10_0000_0000_0000, 53'h10_0000_0000_0000, 0);
    run_op(53'h1555555555555, 53'h0AAAAAAAAAAAA, 1);
    for (int t = 0; t < 6; t++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      run_op(ra[MANT_W-1:0], rb[MANT_W-1:0], int'($urandom_range(0, 2)));
    end
    ra = {$urandom, $urandom};
    rb = {$urandom, $urandom};
    run_op(ra[MANT_W-1:0] | 53'h10_0000_0000_0000, rb[MANT_W-1:0], 10);

    // Abort mid-operation with an asynchronous reset at cnt=10.
    bus.in_valid = 1'b1;
    bus.a = all_ones;
    bus.b = all_ones;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_in_ready", bus.in_ready, 1'b1);
    check("abort_out_valid", bus.out_valid, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_p", bus.p, '0);
    check("abort_pp_v", bus.pp_v, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    seen_valid = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen_valid++;
    end
    check("abort_no_result", seen_valid, 0);

    run_op(53'd3, 53'd5, 0);
    run_op(53'd0, all_ones, 0);
    run_op(all_ones, 53'd0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
